// File: rtl/wb_ctrl_pkg.sv
// Shared types for the writeback sequencer: result-mux select codes and FSM states.
package wb_ctrl_pkg;

   localparam int unsigned RD_W_DEFAULT = 5;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      StIdle,
      StLookup,
      StMissWait,
      StWb
   } wb_state_e;

endpackage

// File: rtl/wb_miss_timer.sv
// Counts cycles spent waiting on a D-cache refill; flags the last allowed cycle.
module wb_miss_timer #(
   parameter int unsigned MISS_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(MISS_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(MISS_TIMEOUT - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/wb_seq_ctrl.sv
// Writeback sequencer: drives the result mux / RF write port and stalls on D-cache loads.
// Define WB_PERF_CNT_EN to build the load hit/miss performance counters.
module wb_seq_ctrl
   import wb_ctrl_pkg::*;
#(
   parameter int unsigned MISS_TIMEOUT = 64,
   parameter int unsigned RD_W         = RD_W_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [1:0]      issue_src,
   input  logic            issue_we,
   input  logic [RD_W-1:0] issue_rd,
   output logic            issue_ready,
   output logic            cache_req,
   input  logic            cache_hit,
   input  logic            cache_fill_done,
   output logic            stall,
   output logic [1:0]      result_src,
   output logic            rf_we,
   output logic [RD_W-1:0] rf_rd,
   output logic            miss_timeout_err,
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count
);

   wb_state_e   state_q;
   result_src_e result_src_q;
   logic        rf_we_q;
   logic [RD_W-1:0] rf_rd_q;
   logic        cache_req_q;
   logic        err_q;
   logic        ld_we_q;
   logic [RD_W-1:0] ld_rd_q;
   logic        timer_expired;

   wb_miss_timer #(
      .MISS_TIMEOUT(MISS_TIMEOUT)
   ) u_miss_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == StLookup),
      .en     (state_q == StMissWait),
      .expired(timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         result_src_q <= RES_ALU;
         rf_we_q      <= 1'b0;
         rf_rd_q      <= '0;
         cache_req_q  <= 1'b0;
         err_q        <= 1'b0;
         ld_we_q      <= 1'b0;
         ld_rd_q      <= '0;
      end else begin
         // Write strobe and select are pulses; rf_rd is left holding its last value.
         result_src_q <= RES_ALU;
         rf_we_q      <= 1'b0;
         cache_req_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (issue_valid) begin
                  if (issue_src == RES_MEM) begin
                     ld_we_q     <= issue_we;
                     ld_rd_q     <= issue_rd;
                     cache_req_q <= 1'b1;
                     state_q     <= StLookup;
                  end else begin
                     result_src_q <= (issue_src == RES_PC4) ? RES_PC4 : RES_ALU;
                     rf_we_q      <= issue_we && (issue_rd != '0);
                     rf_rd_q      <= issue_rd;
                  end
               end
            end
            StLookup: begin
               state_q <= cache_hit ? StWb : StMissWait;
            end
            StMissWait: begin
               if (cache_fill_done) begin
                  state_q <= StWb;
               end else if (timer_expired) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
               end
            end
            StWb: begin
               result_src_q <= RES_MEM;
               rf_we_q      <= ld_we_q && (ld_rd_q != '0);
               rf_rd_q      <= ld_rd_q;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign issue_ready      = (state_q == StIdle);
   assign stall            = (state_q != StIdle) ||
                             (issue_valid && (issue_src == RES_MEM) && (state_q == StIdle));
   assign cache_req        = cache_req_q;
   assign result_src       = result_src_q;
   assign rf_we            = rf_we_q;
   assign rf_rd            = rf_rd_q;
   assign miss_timeout_err = err_q;

`ifdef WB_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == StLookup) begin
         if (cache_hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Directed bench for wb_seq_ctrl: vector table for single-cycle issues, hand sequences for loads.
module tb_wb_seq_ctrl;

   localparam int unsigned RD_W = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid;
   logic [1:0]      issue_src;
   logic            issue_we;
   logic [RD_W-1:0] issue_rd;
   logic            issue_ready;
   logic            cache_req;
   logic            cache_hit;
   logic            cache_fill_done;
   logic            stall;
   logic [1:0]      result_src;
   logic            rf_we;
   logic [RD_W-1:0] rf_rd;
   logic            miss_timeout_err;
   logic [31:0]     hit_count;
   logic [31:0]     miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   wb_seq_ctrl #(
      .MISS_TIMEOUT(8),
      .RD_W        (RD_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .issue_valid     (issue_valid),
      .issue_src       (issue_src),
      .issue_we        (issue_we),
      .issue_rd        (issue_rd),
      .issue_ready     (issue_ready),
      .cache_req       (cache_req),
      .cache_hit       (cache_hit),
      .cache_fill_done (cache_fill_done),
      .stall           (stall),
      .result_src      (result_src),
      .rf_we           (rf_we),
      .rf_rd           (rf_rd),
      .miss_timeout_err(miss_timeout_err),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            valid;
      logic [1:0]      src;
      logic            we;
      logic [RD_W-1:0] rd;
      logic [1:0]      exp_src;
      logic            exp_we;
      logic [RD_W-1:0] exp_rd;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic w, input logic [RD_W-1:0] r);
      issue_valid = v;
      issue_src   = s;
      issue_we    = w;
      issue_rd    = r;
   endtask

   // Issue a load and drive a lookup miss; returns positioned at the first MISS_WAIT cycle.
   task automatic load_miss(input logic [RD_W-1:0] r);
      drive(1'b1, 2'b01, 1'b1, r);
      cyc();
      drive(1'b0, 2'b00, 1'b0, '0);
      cache_hit       = 1'b0;
      cache_fill_done = 1'b0;
      #1;
      chk("miss_lookup_req", 32'(cache_req), 32'd1);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 2'b00, 1'b1, 5'd5,  2'b00, 1'b1, 5'd5};
      vecs[1] = '{1'b1, 2'b10, 1'b1, 5'd1,  2'b10, 1'b1, 5'd1};
      vecs[2] = '{1'b1, 2'b00, 1'b1, 5'd0,  2'b00, 1'b0, 5'd0};
      vecs[3] = '{1'b1, 2'b11, 1'b1, 5'd9,  2'b00, 1'b1, 5'd9};
      vecs[4] = '{1'b1, 2'b10, 1'b0, 5'd12, 2'b10, 1'b0, 5'd12};
      vecs[5] = '{1'b0, 2'b00, 1'b1, 5'd3,  2'b00, 1'b0, 5'd12};
      vecs[6] = '{1'b0, 2'b01, 1'b1, 5'd4,  2'b00, 1'b0, 5'd12};
      vecs[7] = '{1'b1, 2'b00, 1'b1, 5'd31, 2'b00, 1'b1, 5'd31};

      reset           = 1'b1;
      cache_hit       = 1'b0;
      cache_fill_done = 1'b0;
      drive(1'b0, 2'b00, 1'b0, '0);
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("rst_result_src", 32'(result_src), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_cache_req", 32'(cache_req), 32'd0);
      chk("rst_err", 32'(miss_timeout_err), 32'd0);
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);

      // Back-to-back single-cycle issues
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].valid, vecs[i].src, vecs[i].we, vecs[i].rd);
         #1;
         chk("vec_stall", 32'(stall), 32'd0);
         chk("vec_ready", 32'(issue_ready), 32'd1);
         cyc();
         chk("vec_result_src", 32'(result_src), 32'(vecs[i].exp_src));
         chk("vec_rf_we", 32'(rf_we), 32'(vecs[i].exp_we));
         chk("vec_rf_rd", 32'(rf_rd), 32'(vecs[i].exp_rd));
      end

      // Load hit: 3 cycles issue to rf_we
      drive(1'b1, 2'b01, 1'b1, 5'd7);
      #1;
      chk("hit_issue_stall", 32'(stall), 32'd1);
      chk("hit_issue_ready", 32'(issue_ready), 32'd1);
      chk("hit_issue_req", 32'(cache_req), 32'd0);
      cyc();
      drive(1'b0, 2'b00, 1'b0, '0);
      cache_hit = 1'b1;
      #1;
      chk("hit_lookup_req", 32'(cache_req), 32'd1);
      chk("hit_lookup_stall", 32'(stall), 32'd1);
      chk("hit_lookup_ready", 32'(issue_ready), 32'd0);
      cyc();
      cache_hit = 1'b0;
      #1;
      chk("hit_wb_req", 32'(cache_req), 32'd0);
      chk("hit_wb_stall", 32'(stall), 32'd1);
      chk("hit_wb_rf_we", 32'(rf_we), 32'd0);
      cyc();
      chk("hit_rf_we", 32'(rf_we), 32'd1);
      chk("hit_result_src", 32'(result_src), 32'd1);
      chk("hit_rf_rd", 32'(rf_rd), 32'd7);
      chk("hit_done_stall", 32'(stall), 32'd0);
      cyc();
      chk("hit_after_we", 32'(rf_we), 32'd0);
      chk("hit_after_src", 32'(result_src), 32'd0);
      chk("hit_after_rd_hold", 32'(rf_rd), 32'd7);

      // Load miss; fill_done during LOOKUP and hit during MISS_WAIT must be ignored
      drive(1'b1, 2'b01, 1'b1, 5'd8);
      cyc();
      drive(1'b0, 2'b00, 1'b0, '0);
      cache_hit       = 1'b0;
      cache_fill_done = 1'b1;
      #1;
      chk("miss_lookup_req", 32'(cache_req), 32'd1);
      cyc();
      cache_fill_done = 1'b0;
      cache_hit       = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("miss_wait_ready", 32'(issue_ready), 32'd0);
         chk("miss_wait_rf_we", 32'(rf_we), 32'd0);
         cyc();
      end
      cache_hit       = 1'b0;
      cache_fill_done = 1'b1;
      #1;
      chk("miss_fill_stall", 32'(stall), 32'd1);
      cyc();
      cache_fill_done = 1'b0;
      #1;
      chk("miss_wb_rf_we", 32'(rf_we), 32'd0);
      chk("miss_wb_ready", 32'(issue_ready), 32'd0);
      cyc();
      chk("miss_rf_we", 32'(rf_we), 32'd1);
      chk("miss_rf_rd", 32'(rf_rd), 32'd8);
      chk("miss_result_src", 32'(result_src), 32'd1);
      cyc();
      chk("miss_after_rf_we", 32'(rf_we), 32'd0);
      chk("miss_after_ready", 32'(issue_ready), 32'd1);
`ifdef WB_PERF_CNT_EN
      chk("perf_hit_count", hit_count, 32'd1);
      chk("perf_miss_count", miss_count, 32'd1);
`else
      chk("perf_hit_count_off", hit_count, 32'd0);
      chk("perf_miss_count_off", miss_count, 32'd0);
`endif

      // Fill on the last allowed MISS_WAIT cycle beats the timeout
      load_miss(5'd11);
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("prio_wait_ready", 32'(issue_ready), 32'd0);
         cyc();
      end
      cache_fill_done = 1'b1;
      #1;
      chk("prio_last_ready", 32'(issue_ready), 32'd0);
      cyc();
      cache_fill_done = 1'b0;
      cyc();
      chk("prio_rf_we", 32'(rf_we), 32'd1);
      chk("prio_rf_rd", 32'(rf_rd), 32'd11);
      chk("prio_err", 32'(miss_timeout_err), 32'd0);

      // Timeout after 8 MISS_WAIT cycles with no fill
      load_miss(5'd10);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("to_wait_ready", 32'(issue_ready), 32'd0);
         chk("to_wait_rf_we", 32'(rf_we), 32'd0);
         cyc();
      end
      chk("to_ready", 32'(issue_ready), 32'd1);
      chk("to_stall", 32'(stall), 32'd0);
      chk("to_rf_we", 32'(rf_we), 32'd0);
      chk("to_err", 32'(miss_timeout_err), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("to_err_sticky", 32'(miss_timeout_err), 32'd1);
         chk("to_after_rf_we", 32'(rf_we), 32'd0);
      end
`ifdef WB_PERF_CNT_EN
      chk("perf_miss_count3", miss_count, 32'd3);
`endif

      // Reset while in MISS_WAIT discards the load; late fill ignored
      load_miss(5'd13);
      cyc();
      cyc();
      #1;
      chk("rstmw_ready_before", 32'(issue_ready), 32'd0);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("rstmw_ready", 32'(issue_ready), 32'd1);
      chk("rstmw_stall", 32'(stall), 32'd0);
      chk("rstmw_rf_we", 32'(rf_we), 32'd0);
      chk("rstmw_rf_rd", 32'(rf_rd), 32'd0);
      chk("rstmw_err", 32'(miss_timeout_err), 32'd0);
      chk("rstmw_miss_count", miss_count, 32'd0);
      cache_fill_done = 1'b1;
      cyc();
      cache_fill_done = 1'b0;
      chk("late_fill_rf_we", 32'(rf_we), 32'd0);
      chk("late_fill_ready", 32'(issue_ready), 32'd1);
      cyc();
      chk("late_fill_rf_we2", 32'(rf_we), 32'd0);
      chk("late_fill_stall", 32'(stall), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
